// File: rtl/inst_fetch_buf.sv
// Fetch stage: issues PCs to a synchronous instruction ROM, pairs each returned instruction with
// its PC and queues the pairs for the decode stage.
module inst_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_ce,
  output logic              o_stall,
  output logic              o_rom_ce,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  input  logic              i_flush,
  output logic              o_id_valid,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [DATA_W-1:0] o_id_inst,
  input  logic              i_id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              inflight;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] last_pc;
  logic [DATA_W-1:0] last_inst;
  logic              issue;
  logic              push;
  logic              pop;

  // Reserve a slot for every outstanding ROM read so a response can always be pushed.
  assign o_stall    = ({1'b0, count} + (CNT_W + 1)'(inflight)) >= (CNT_W + 1)'(DEPTH);
  assign issue      = i_ce & ~o_stall & ~i_flush;
  assign o_rom_ce   = issue;
  assign o_rom_addr = i_pc;

  // Decode handshake: an entry transfers on a rising edge where o_id_valid & i_id_ready;
  // o_id_valid never depends on i_id_ready and the head is stable until it transfers.
  assign o_id_valid = (count != '0);
  assign push       = inflight & ~i_flush;
  assign pop        = o_id_valid & i_id_ready & ~i_flush;
  assign o_id_pc    = o_id_valid ? pc_mem[rd_ptr]   : last_pc;
  assign o_id_inst  = o_id_valid ? inst_mem[rd_ptr] : last_inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      inflight  <= 1'b0;
      req_pc    <= '0;
      last_pc   <= '0;
      last_inst <= '0;
    end else begin
      inflight <= issue;
      if (issue) req_pc <= i_pc;
      // Remember the head being shown so the outputs hold it once the queue empties.
      if (o_id_valid) begin
        last_pc   <= pc_mem[rd_ptr];
        last_inst <= inst_mem[rd_ptr];
      end
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= i_rom_data;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && count == CNT_W'(DEPTH)))
    else $error("inst_fetch_buf: push into full queue");

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: directed scenarios plus randomized traffic against a queue-based
// model of the fetch buffer, the PC register and the ROM.
module tb_inst_fetch_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_pc;
  logic        i_ce;
  logic        o_stall;
  logic        o_rom_ce;
  logic [31:0] o_rom_addr;
  logic [31:0] i_rom_data;
  logic        i_flush;
  logic        o_id_valid;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_inst;
  logic        i_id_ready;

  inst_fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pc       (i_pc),
    .i_ce       (i_ce),
    .o_stall    (o_stall),
    .o_rom_ce   (o_rom_ce),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (i_rom_data),
    .i_flush    (i_flush),
    .o_id_valid (o_id_valid),
    .o_id_pc    (o_id_pc),
    .o_id_inst  (o_id_inst),
    .i_id_ready (i_id_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  bit          infl;
  logic [31:0] infl_pc;
  logic [31:0] pc;
  logic [31:0] last_pc;
  logic [31:0] last_inst;
  bit          exp_issue;
  int          n_vec;
  int          n_miss;
  logic [31:0] mark;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    infl      = 1'b0;
    infl_pc   = '0;
    pc        = '0;
    last_pc   = '0;
    last_inst = '0;
  endtask

  task automatic check_outputs();
    bit exp_stall;
    exp_stall = (exp_q.size() + int'(infl)) >= 4;
    exp_issue = i_ce && !exp_stall && !i_flush;
    chk("stall", 32'(o_stall), 32'(exp_stall));
    chk("rom_ce", 32'(o_rom_ce), 32'(exp_issue));
    if (exp_issue) chk("rom_addr", o_rom_addr, pc);
    chk("id_valid", 32'(o_id_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("id_pc", o_id_pc, exp_q[0].pc);
      chk("id_inst", o_id_inst, exp_q[0].inst);
      last_pc   = exp_q[0].pc;
      last_inst = exp_q[0].inst;
    end else begin
      chk("id_pc_hold", o_id_pc, last_pc);
      chk("id_inst_hold", o_id_inst, last_inst);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    if (i_flush) begin
      exp_q.delete();
      infl = 1'b0;
    end else begin
      if (exp_q.size() != 0 && i_id_ready) void'(exp_q.pop_front());
      if (infl) begin
        e.pc   = infl_pc;
        e.inst = rom_f(infl_pc);
        exp_q.push_back(e);
      end
      infl = exp_issue;
      if (exp_issue) begin
        infl_pc = pc;
        pc      = pc + 32'd4;
      end
    end
  endtask

  // One clock: drive inputs after the edge, check at the falling edge, advance the model at the edge.
  task automatic cycle(input bit ce, input bit rdy, input bit fl);
    i_ce       = ce;
    i_id_ready = rdy;
    i_flush    = fl;
    i_pc       = pc;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    i_rom_data = infl ? rom_f(infl_pc) : $urandom;
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b1;
    i_ce       = 1'b0;
    i_id_ready = 1'b0;
    i_flush    = 1'b0;
    i_pc       = '0;
    i_rom_data = '0;
    model_reset();

    #12;
    chk("rst_valid", 32'(o_id_valid), 32'd0);
    chk("rst_pc", o_id_pc, 32'd0);
    chk("rst_inst", o_id_inst, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_rom_ce", 32'(o_rom_ce), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming with decode always ready: two-cycle latency, one entry per cycle.
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    chk("lat_valid", 32'(o_id_valid), 32'd1);
    chk("lat_pc0", o_id_pc, 32'd0);
    chk("lat_inst0", o_id_inst, 32'hA5A5_0000);
    cycle(1, 1, 0);
    chk("stream_pc4", o_id_pc, 32'd4);
    chk("stream_inst4", o_id_inst, 32'hA5A5_0004);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);

    // Backpressure: queue fills to four entries and the PC is held.
    mark = pc;
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    chk("bp_stall", 32'(o_stall), 32'd1);
    chk("bp_head", o_id_pc, mark);
    chk("bp_held_pc", pc, mark + 32'd16);
    // Full queue with a single pop frees a slot for the next issue.
    cycle(1, 1, 0);
    chk("full_pop_stall", 32'(o_stall), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);

    // Flush with two queued entries and one read in flight.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    mark = pc;
    cycle(1, 0, 1);
    chk("flush_valid", 32'(o_id_valid), 32'd0);
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    chk("flush_first_pc", o_id_pc, mark);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);

    // Asynchronous reset in the middle of traffic with three entries queued.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    #2;
    rst  = 1'b1;
    i_ce = 1'b0;
    #1;
    chk("arst_valid", 32'(o_id_valid), 32'd0);
    chk("arst_stall", 32'(o_stall), 32'd0);
    model_reset();
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
    i_ce = 1'b1;
    i_pc = pc;
    #1;
    chk("arst_first_addr", o_rom_addr, 32'd0);
    cycle(1, 1, 0);

    // Randomized fill/drain rounds with occasional flushes.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++)
        cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
      for (int i = 0; i < 8; i++)
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 25) == 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
